// File: rtl/tft_window_streamer_if.sv
// Byte stream from the window streamer to the SPI master: one byte per valid&ready beat,
// with byteDc selecting command (0) or data (1).
interface tft_window_streamer_if;
  logic       byteValid;
  logic [7:0] byteData;
  logic       byteDc;
  logic       byteReady;

  modport master (output byteValid, byteData, byteDc, input byteReady);
  modport slave  (input byteValid, byteData, byteDc, output byteReady);
endinterface

// File: rtl/tft_window_streamer.sv
// TFT panel driver: power-up reset/init-ROM playback, then streams rectangular windows from pixel memory.
// Pixel word is fetched in one cycle; every byte holds on the bus until byteReady, with no combinational ready path.
module tft_window_streamer #(
  parameter int COLS             = 240,
  parameter int ROWS             = 320,
  parameter int PIXEL_BYTES      = 2,
  parameter int INIT_AW          = 8,
  parameter int PIX_AW           = 17,
  parameter int RESET_TICKS      = 500000,
  parameter int POST_RESET_TICKS = 6000000,
  parameter int UNIT_TICKS       = 50000
) (
  input  logic                     CLK_I,
  input  logic                     RST_I,
  input  logic                     start,
  input  logic                     continuous,
  input  logic [15:0]              winX0,
  input  logic [15:0]              winX1,
  input  logic [15:0]              winY0,
  input  logic [15:0]              winY1,
  output logic [INIT_AW-1:0]       initAddr,
  input  logic [9:0]               initData,
  output logic [PIX_AW-1:0]        pixAddr,
  input  logic [8*PIXEL_BYTES-1:0] pixData,
  tft_window_streamer_if.master    byteBus,
  output logic                     tftReset,
  output logic                     ready,
  output logic                     busy,
  output logic                     done,
  output logic                     winErr
);

  localparam int DELAY_MAX = 255 * UNIT_TICKS;
  localparam int HOLD_MAX  = (RESET_TICKS > POST_RESET_TICKS) ? RESET_TICKS : POST_RESET_TICKS;
  localparam int TICK_MAX  = (DELAY_MAX > HOLD_MAX) ? DELAY_MAX : HOLD_MAX;
  localparam int CNT_W     = $clog2(TICK_MAX + 1);
  localparam int BI_W      = (PIXEL_BYTES > 1) ? $clog2(PIXEL_BYTES) : 1;

  typedef enum logic [3:0] {
    RST_HOLD, RST_WAIT, INIT_FETCH, INIT_SEND, INIT_DELAY,
    IDLE, WIN_CMD, PIX_FETCH, PIX_SEND, DONE
  } state_t;

  state_t                   state, nextState;
  logic [CNT_W-1:0]         tickCnt;
  logic                     fetchWait;
  logic [7:0]               initByte;
  logic                     initDc;
  logic [15:0]              x0, x1, y0, y1;
  logic [15:0]              curX, curY;
  logic [3:0]               cmdIdx;
  logic [PIX_AW-1:0]        rowBase;
  logic                     primed;
  logic [8*PIXEL_BYTES-1:0] pixWord;
  logic [BI_W-1:0]          byteIdx;
  logic                     lastPix;

  logic       offer, accept, initLast, winBad, lastByte;
  logic [7:0] outByte, cmdByte;
  logic       outDc;

  assign initLast = &initAddr;
  assign lastByte = (byteIdx == BI_W'(PIXEL_BYTES - 1));
  assign winBad   = (winX0 > winX1) || (winY0 > winY1) ||
                    (winX1 >= 16'(COLS)) || (winY1 >= 16'(ROWS));

  always_comb begin
    cmdByte = 8'h00;
    case (cmdIdx)
      4'd0:    cmdByte = 8'h2A;
      4'd1:    cmdByte = x0[15:8];
      4'd2:    cmdByte = x0[7:0];
      4'd3:    cmdByte = x1[15:8];
      4'd4:    cmdByte = x1[7:0];
      4'd5:    cmdByte = 8'h2B;
      4'd6:    cmdByte = y0[15:8];
      4'd7:    cmdByte = y0[7:0];
      4'd8:    cmdByte = y1[15:8];
      4'd9:    cmdByte = y1[7:0];
      4'd10:   cmdByte = 8'h2C;
      default: cmdByte = 8'h00;
    endcase
  end

  // 0x2C is held back until the first pixel address has been on pixAddr for a full cycle.
  always_comb begin
    offer   = 1'b0;
    outByte = 8'h00;
    outDc   = 1'b0;
    case (state)
      INIT_SEND: begin
        offer   = 1'b1;
        outByte = initByte;
        outDc   = initDc;
      end
      WIN_CMD: begin
        offer   = (cmdIdx != 4'd10) || primed;
        outByte = cmdByte;
        outDc   = !((cmdIdx == 4'd0) || (cmdIdx == 4'd5) || (cmdIdx == 4'd10));
      end
      PIX_SEND: begin
        offer = 1'b1;
        outDc = 1'b1;
        for (int i = 0; i < PIXEL_BYTES; i++) begin
          if (byteIdx == BI_W'(i)) outByte = pixWord[8*(PIXEL_BYTES-1-i) +: 8];
        end
      end
      default: ;
    endcase
  end

  assign accept            = offer && byteBus.byteReady;
  assign byteBus.byteValid = offer;
  assign byteBus.byteData  = outByte;
  assign byteBus.byteDc    = outDc;

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) state <= RST_HOLD;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    tftReset  = (state != RST_HOLD);
    ready     = (state == IDLE);
    busy      = (state != IDLE);
    done      = (state == DONE);
    case (state)
      RST_HOLD:   if (tickCnt == CNT_W'(RESET_TICKS - 1)) nextState = RST_WAIT;
      RST_WAIT:   if (tickCnt == CNT_W'(POST_RESET_TICKS - 1)) nextState = INIT_FETCH;
      INIT_FETCH: begin
        if (fetchWait) begin
          case (initData[9:8])
            2'b00, 2'b01: nextState = INIT_SEND;
            2'b10: begin
              if (initData[7:0] != 8'd0) nextState = INIT_DELAY;
              else if (initLast)         nextState = IDLE;
            end
            default:      nextState = IDLE;
          endcase
        end
      end
      INIT_SEND:  if (accept) nextState = initLast ? IDLE : INIT_FETCH;
      INIT_DELAY: if (tickCnt == '0) nextState = initLast ? IDLE : INIT_FETCH;
      IDLE:       if (start && !winBad) nextState = WIN_CMD;
      WIN_CMD:    if (accept && (cmdIdx == 4'd10)) nextState = PIX_FETCH;
      PIX_FETCH:  nextState = PIX_SEND;
      PIX_SEND:   if (accept && lastByte) nextState = lastPix ? DONE : PIX_FETCH;
      DONE:       nextState = continuous ? WIN_CMD : IDLE;
      default:    nextState = RST_HOLD;
    endcase
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      tickCnt   <= '0;
      fetchWait <= 1'b0;
      initAddr  <= '0;
      initByte  <= 8'h00;
      initDc    <= 1'b0;
      x0        <= 16'd0;
      x1        <= 16'd0;
      y0        <= 16'd0;
      y1        <= 16'd0;
      curX      <= 16'd0;
      curY      <= 16'd0;
      cmdIdx    <= 4'd0;
      rowBase   <= '0;
      primed    <= 1'b0;
      pixAddr   <= '0;
      pixWord   <= '0;
      byteIdx   <= '0;
      lastPix   <= 1'b0;
      winErr    <= 1'b0;
    end else begin
      winErr <= 1'b0;
      case (state)
        RST_HOLD: begin
          if (tickCnt == CNT_W'(RESET_TICKS - 1)) tickCnt <= '0;
          else                                    tickCnt <= tickCnt + CNT_W'(1);
        end
        RST_WAIT: begin
          fetchWait <= 1'b0;
          initAddr  <= '0;
          if (tickCnt == CNT_W'(POST_RESET_TICKS - 1)) tickCnt <= '0;
          else                                         tickCnt <= tickCnt + CNT_W'(1);
        end
        INIT_FETCH: begin
          fetchWait <= !fetchWait;
          if (fetchWait) begin
            initByte <= initData[7:0];
            initDc   <= initData[8];
            if (initData[9:8] == 2'b10) begin
              if (initData[7:0] == 8'd0) begin
                if (!initLast) initAddr <= initAddr + INIT_AW'(1);
              end else begin
                tickCnt <= CNT_W'(initData[7:0]) * CNT_W'(UNIT_TICKS) - CNT_W'(1);
              end
            end
          end
        end
        INIT_SEND: if (accept && !initLast) initAddr <= initAddr + INIT_AW'(1);
        INIT_DELAY: begin
          if (tickCnt == '0) begin
            if (!initLast) initAddr <= initAddr + INIT_AW'(1);
          end else begin
            tickCnt <= tickCnt - CNT_W'(1);
          end
        end
        IDLE: begin
          winErr <= start && winBad;
          if (start && !winBad) begin
            x0      <= winX0;
            x1      <= winX1;
            y0      <= winY0;
            y1      <= winY1;
            cmdIdx  <= 4'd0;
            curY    <= 16'd0;
            rowBase <= '0;
            primed  <= 1'b0;
          end
        end
        // The row-base accumulator walks up to Y0 while the command bytes go out.
        WIN_CMD: begin
          if (curY != y0) begin
            curY    <= curY + 16'd1;
            rowBase <= rowBase + PIX_AW'(COLS);
          end else begin
            curX    <= x0;
            pixAddr <= rowBase + PIX_AW'(x0);
            primed  <= 1'b1;
          end
          if (accept) cmdIdx <= cmdIdx + 4'd1;
        end
        // Capture this pixel and put the next address out so memory has it by the next fetch.
        PIX_FETCH: begin
          pixWord <= pixData;
          byteIdx <= '0;
          lastPix <= (curX == x1) && (curY == y1);
          if (!((curX == x1) && (curY == y1))) begin
            if (curX == x1) begin
              curX    <= x0;
              curY    <= curY + 16'd1;
              rowBase <= rowBase + PIX_AW'(COLS);
              pixAddr <= rowBase + PIX_AW'(COLS) + PIX_AW'(x0);
            end else begin
              curX    <= curX + 16'd1;
              pixAddr <= pixAddr + PIX_AW'(1);
            end
          end
        end
        PIX_SEND: if (accept) byteIdx <= byteIdx + BI_W'(1);
        DONE: begin
          if (continuous) begin
            x0      <= 16'd0;
            x1      <= 16'(COLS - 1);
            y0      <= 16'd0;
            y1      <= 16'(ROWS - 1);
            cmdIdx  <= 4'd0;
            curY    <= 16'd0;
            rowBase <= '0;
            primed  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tft_window_streamer.sv
// Randomized bench for tft_window_streamer: byte stream scored against a frame-level model queue.
module tb_tft_window_streamer;
  localparam int COLS = 4, ROWS = 3, PB = 2, IAW = 8, PAW = 4, RT = 4, PRT = 3, UT = 5;

  logic            CLK_I = 1'b0;
  logic            RST_I = 1'b1;
  logic            start = 1'b0, continuous = 1'b0;
  logic [15:0]     winX0 = '0, winX1 = '0, winY0 = '0, winY1 = '0;
  logic [IAW-1:0]  initAddr;
  logic [9:0]      initData;
  logic [PAW-1:0]  pixAddr;
  logic [8*PB-1:0] pixData;
  logic            tftReset, ready, busy, done, winErr;

  tft_window_streamer_if byteBus();

  tft_window_streamer #(.COLS(COLS), .ROWS(ROWS), .PIXEL_BYTES(PB), .INIT_AW(IAW), .PIX_AW(PAW),
                        .RESET_TICKS(RT), .POST_RESET_TICKS(PRT), .UNIT_TICKS(UT)) dut (
    .CLK_I(CLK_I), .RST_I(RST_I), .start(start), .continuous(continuous),
    .winX0(winX0), .winX1(winX1), .winY0(winY0), .winY1(winY1),
    .initAddr(initAddr), .initData(initData), .pixAddr(pixAddr), .pixData(pixData),
    .byteBus(byteBus), .tftReset(tftReset), .ready(ready), .busy(busy), .done(done), .winErr(winErr));

  always #5 CLK_I = ~CLK_I;

  function automatic logic [9:0] romWord(input logic [IAW-1:0] a);
    case (a)
      8'd0:    return 10'h001;
      8'd1:    return 10'h202;
      8'd2:    return 10'h155;
      8'd3:    return 10'h300;
      default: return 10'h000;
    endcase
  endfunction

  function automatic logic [15:0] memWord(input int a);
    return 16'hA000 + 16'(a) * 16'h0101;
  endfunction

  always @(posedge CLK_I) begin
    initData <= romWord(initAddr);
    pixData  <= memWord(int'(pixAddr));
  end

  int passCnt = 0, totalCnt = 0;
  task automatic check(input string name, input longint act, input longint exp);
    totalCnt++;
    if (act == exp) passCnt++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  // Model: every byte the panel must receive, {dc, data}, in order.
  logic [8:0] expQ[$];
  task automatic pushByte(input logic dc, input logic [7:0] d);
    expQ.push_back({dc, d});
  endtask
  task automatic pushWindow(input int x0, input int y0, input int x1, input int y1);
    logic [15:0] w;
    pushByte(0, 8'h2A); pushByte(1, 8'(x0 >> 8)); pushByte(1, 8'(x0)); pushByte(1, 8'(x1 >> 8)); pushByte(1, 8'(x1));
    pushByte(0, 8'h2B); pushByte(1, 8'(y0 >> 8)); pushByte(1, 8'(y0)); pushByte(1, 8'(y1 >> 8)); pushByte(1, 8'(y1));
    pushByte(0, 8'h2C);
    for (int y = y0; y <= y1; y++)
      for (int x = x0; x <= x1; x++) begin
        w = memWord(y * COLS + x);
        for (int b = PB - 1; b >= 0; b--) pushByte(1, w[8*b +: 8]);
      end
  endtask

  int accCnt = 0, offerCnt = 0, doneCnt = 0, errCnt = 0, cycle = 0;
  int accCyc[$];
  bit randReady = 0;
  int stallAt = -1, stallLen = 0, stallDone = 0;

  initial begin : monitor
    bit         prevStall, prevDone, rdy;
    logic [8:0] prevByte, cur;
    prevStall = 0; prevDone = 0; prevByte = '0;
    byteBus.byteReady = 1'b0;
    forever begin
      @(negedge CLK_I);
      cycle++;
      if (RST_I) begin
        prevStall = 0; prevDone = 0; byteBus.byteReady = 1'b0;
        continue;
      end
      cur = {byteBus.byteDc, byteBus.byteData};
      check("ready_vs_busy", busy, !ready);
      if (done) begin
        check("done_one_cycle", prevDone, 0);
        doneCnt++;
      end
      prevDone = done;
      if (winErr) errCnt++;
      if (prevStall) begin
        check("hold_valid", byteBus.byteValid, 1);
        check("hold_byte", cur, prevByte);
      end
      if (byteBus.byteValid && accCnt == stallAt && stallDone < stallLen) begin
        rdy = 0; stallDone++;
      end else if (randReady) rdy = ($urandom_range(0, 3) != 0);
      else rdy = 1;
      byteBus.byteReady = rdy;
      if (byteBus.byteValid) offerCnt++;
      if (byteBus.byteValid && rdy) begin
        accCnt++;
        accCyc.push_back(cycle);
        check("byte_expected", expQ.size() > 0, 1);
        if (expQ.size() > 0) check("byte_value", cur, expQ.pop_front());
        prevStall = 0;
      end else prevStall = byteBus.byteValid;
      prevByte = cur;
    end
  end

  task automatic pulseStart(input int x0, input int y0, input int x1, input int y1);
    @(negedge CLK_I);
    winX0 = 16'(x0); winY0 = 16'(y0); winX1 = 16'(x1); winY1 = 16'(y1);
    start = 1'b1;
    @(negedge CLK_I);
    start = 1'b0;
  endtask

  task automatic waitReady(input int budget, input string name);
    int n = 0;
    while (!ready && n < budget) begin @(negedge CLK_I); n++; end
    check(name, ready, 1);
  endtask

  task automatic waitDone(input int target, input int budget, input string name);
    int n = 0;
    while (doneCnt < target && n < budget) begin @(posedge CLK_I); n++; end
    check(name, doneCnt >= target, 1);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: time limit reached, %0d/%0d", passCnt, totalCnt);
    $fatal(1, "timeout");
  end

  initial begin : main
    int lows, d0, e0, o0, a0, mine, n, gap;
    bit readySeen;
    int errWin[4][4] = '{'{3, 0, 2, 0}, '{0, 0, 4, 0}, '{0, 0, 0, 3}, '{0, 2, 0, 1}};
    int rx0, rx1, ry0, ry1;

    repeat (3) @(negedge CLK_I);
    check("rst_tftReset", tftReset, 0);
    check("rst_byteValid", byteBus.byteValid, 0);
    check("rst_done", done, 0);
    check("rst_winErr", winErr, 0);
    check("rst_ready", ready, 0);
    check("rst_busy", busy, 1);
    check("rst_initAddr", initAddr, 0);
    check("rst_pixAddr", pixAddr, 0);

    pushByte(0, 8'h01); pushByte(1, 8'h55);
    #1 RST_I = 1'b0;
    lows = 0;
    while (!tftReset && lows < 50) begin lows++; @(negedge CLK_I); end
    check("reset_low_clocks", lows, RT);
    waitReady(300, "init_ready");
    @(posedge CLK_I);
    check("init_drained", expQ.size(), 0);
    check("init_byte_count", accCyc.size(), 2);
    gap = (accCyc.size() == 2) ? accCyc[1] - accCyc[0] : 0;
    check("init_gap_ge10", gap >= 10, 1);

    pushWindow(1, 1, 2, 2);
    check("model_len", expQ.size(), 11 + 4 * PB);
    check("model_b0", expQ[0], 9'h02A);
    check("model_b4", expQ[4], 9'h102);
    check("model_b10", expQ[10], 9'h02C);
    check("model_pix5_hi", expQ[11], 9'h1A5);
    check("model_pix5_lo", expQ[12], 9'h105);
    check("model_pix6_hi", expQ[13], 9'h1A6);
    check("model_pix9_hi", expQ[15], 9'h1A9);
    check("model_pix10_lo", expQ[18], 9'h10A);
    d0 = doneCnt;
    pulseStart(1, 1, 2, 2);
    waitDone(d0 + 1, 200, "win_done");
    repeat (3) @(negedge CLK_I);
    @(posedge CLK_I);
    check("win_drained", expQ.size(), 0);
    check("win_done_once", doneCnt - d0, 1);
    check("win_ready_after", ready, 1);

    for (int i = 0; i < 4; i++) begin
      @(posedge CLK_I);
      e0 = errCnt; o0 = offerCnt;
      pulseStart(errWin[i][0], errWin[i][1], errWin[i][2], errWin[i][3]);
      repeat (3) @(negedge CLK_I);
      @(posedge CLK_I);
      check("err_pulse", errCnt - e0, 1);
      check("err_no_bytes", offerCnt - o0, 0);
      check("err_ready", ready, 1);
    end

    @(posedge CLK_I);
    stallAt = accCnt + 13; stallLen = 7; stallDone = 0; d0 = doneCnt; e0 = errCnt;
    pushWindow(0, 0, 3, 1);
    pulseStart(0, 0, 3, 1);
    waitDone(d0 + 1, 400, "stall_done");
    check("stall_cycles", stallDone, 7);
    check("stall_drained", expQ.size(), 0);
    stallAt = -1;

    randReady = 1;
    for (int it = 0; it < 6; it++) begin
      if (it == 0) begin rx0 = 2; rx1 = 2; ry0 = 1; ry1 = 1; end
      else begin
        rx0 = $urandom_range(0, COLS - 1); rx1 = $urandom_range(rx0, COLS - 1);
        ry0 = $urandom_range(0, ROWS - 1); ry1 = $urandom_range(ry0, ROWS - 1);
      end
      @(posedge CLK_I);
      d0 = doneCnt;
      pushWindow(rx0, ry0, rx1, ry1);
      if (it == 0) check("single_pixel_len", expQ.size(), 11 + PB);
      pulseStart(rx0, ry0, rx1, ry1);
      if (it == 1) begin
        repeat (4) @(negedge CLK_I);
        pulseStart(0, 0, 0, 0);
      end
      waitDone(d0 + 1, 800, "rand_done");
      repeat (2) @(negedge CLK_I);
      @(posedge CLK_I);
      check("rand_drained", expQ.size(), 0);
    end
    check("no_spurious_winErr", errCnt, e0);

    pushWindow(0, 0, 1, 1);
    pushWindow(0, 0, COLS - 1, ROWS - 1);
    pushWindow(0, 0, COLS - 1, ROWS - 1);
    continuous = 1'b1;
    pulseStart(0, 0, 1, 1);
    mine = 0; readySeen = 0; n = 0;
    while (mine < 3 && n < 3000) begin
      @(negedge CLK_I);
      n++;
      if (ready) readySeen = 1;
      if (done) begin
        mine++;
        if (mine == 3) continuous = 1'b0;
      end
    end
    check("cont_frames", mine, 3);
    check("cont_no_ready", readySeen, 0);
    waitReady(20, "cont_ready_after");
    @(posedge CLK_I);
    check("cont_drained", expQ.size(), 0);

    randReady = 0;
    @(posedge CLK_I);
    a0 = accCnt;
    pushWindow(0, 0, COLS - 1, ROWS - 1);
    pulseStart(0, 0, COLS - 1, ROWS - 1);
    n = 0;
    while (n < 300) begin
      @(posedge CLK_I); #1;
      n++;
      if (accCnt >= a0 + 15 && byteBus.byteValid) break;
    end
    check("midframe_reached", n < 300, 1);
    RST_I = 1'b1;
    #1;
    check("async_rst_byteValid", byteBus.byteValid, 0);
    check("async_rst_tftReset", tftReset, 0);
    check("async_rst_busy", busy, 1);
    expQ.delete();
    pushByte(0, 8'h01); pushByte(1, 8'h55);
    repeat (2) @(negedge CLK_I);
    #1 RST_I = 1'b0;
    waitReady(300, "replay_ready");
    @(posedge CLK_I);
    check("replay_drained", expQ.size(), 0);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end
endmodule

// File: doc/tft_window_streamer.md
TFT_WINDOW_STREAMER -- requirements
Module: tft_window_streamer

Interface
REQ-001 Parameters SHALL be:
  COLS 240: panel columns.
  ROWS 320: panel rows.
  PIXEL_BYTES 2: bytes per pixel, 1..3, sent MSB first.
  INIT_AW 8: init ROM address width.
  PIX_AW 17: pixel memory address width; must satisfy 2^PIX_AW >= COLS*ROWS.
  RESET_TICKS 500000: clocks tftReset is held low.
  POST_RESET_TICKS 6000000: clocks waited after release.
  UNIT_TICKS 50000: clocks per init-ROM delay unit.
REQ-002 Ports SHALL be:
  CLK_I  in  1  sole clock, rising edge.
  RST_I  in  1  reset, asynchronous, active-high.
  start  in  1  one-cycle request to stream the latched window.
  continuous  in  1  when 1, restart the full-frame window automatically after each DONE.
  winX0, winX1  in  16  inclusive column bounds.
  winY0, winY1  in  16  inclusive row bounds.
  initAddr  out  INIT_AW  init ROM address.
  initData  in  10  [9:8] type: 00 cmd, 01 data, 10 delay in [7:0] units, 11 end; [7:0] payload.
  pixAddr  out  PIX_AW  pixel memory address.
  pixData  in  8*PIXEL_BYTES  pixel word; synchronous read, valid 1 cycle after pixAddr.
  byteValid  out  1  byte offered to SPI master.
  byteData  out  8  byte value.
  byteDc  out  1  0 = command, 1 = data.
  byteReady  in  1  SPI master accepts byte when byteValid&byteReady.
  tftReset  out  1  panel reset, active-low.
  ready  out  1  IDLE and init complete.
  busy  out  1  window or init in progress.
  done  out  1  one-cycle pulse after last pixel byte accepted.
  winErr  out  1  one-cycle pulse on rejected window.

Function
REQ-003 The FSM SHALL have the states RST_HOLD, RST_WAIT, INIT_FETCH, INIT_SEND, INIT_DELAY, IDLE, WIN_CMD, PIX_FETCH, PIX_SEND, DONE.
REQ-004 RST_HOLD SHALL drive tftReset=0 for RESET_TICKS clocks, then transition to RST_WAIT with tftReset=1.
REQ-005 RST_WAIT SHALL wait POST_RESET_TICKS clocks, then enter INIT_FETCH with initAddr=0.
REQ-006 INIT_FETCH SHALL allow one ROM-read cycle, then decode initData:
  type 00/01: go to INIT_SEND with byteDc=type[0].
  type 10: go to INIT_DELAY for payload*UNIT_TICKS clocks; payload 0 means 0 clocks.
  type 11: go to IDLE.
REQ-007 initAddr SHALL increment after each accepted byte or completed delay; at the all-ones address without an end entry, the FSM SHALL enter IDLE.
REQ-008 byteValid, byteData and byteDc SHALL hold stable until byteReady is sampled high; the next byte SHALL NOT be offered in the same cycle it is accepted.
REQ-009 In IDLE, start=1 SHALL latch the window bounds.
  Window rejected if X0>X1, Y0>Y1, X1>=COLS or Y1>=ROWS.
  On rejection: winErr pulses, FSM stays in IDLE.
  start outside IDLE SHALL be ignored.
REQ-010 WIN_CMD SHALL send 11 bytes, in order:
  0x2A (cmd), X0[15:8], X0[7:0], X1[15:8], X1[7:0] (data);
  0x2B (cmd), Y0[15:8], Y0[7:0], Y1[15:8], Y1[7:0] (data);
  0x2C (cmd).
REQ-011 Pixel address SHALL be y*COLS+x, computed by a row-base accumulator (add COLS per row); no multiplier.
REQ-012 Pixel order SHALL be x from X0 to X1 inside y from Y0 to Y1; x wraps to X0 and y increments when x==X1.
REQ-013 PIX_FETCH SHALL take 1 cycle; PIX_SEND SHALL emit PIXEL_BYTES data bytes (byteDc=1), MSB first, from the word registered at the end of PIX_FETCH.
REQ-014 After the last byte of pixel (X1,Y1) is accepted, the FSM SHALL enter DONE, pulse done for 1 cycle, then go to IDLE.
REQ-015 If continuous=1 in DONE, the FSM SHALL go directly to WIN_CMD with window (0,0)-(COLS-1,ROWS-1) and skip IDLE.
REQ-016 ready SHALL be 1 only in IDLE; busy SHALL be the inverse of ready.
REQ-017 A single-pixel window (X0==X1, Y0==Y1) SHALL send exactly 11+PIXEL_BYTES bytes.
REQ-018 Delay counters SHALL be wide enough for 255*UNIT_TICKS and for max(RESET_TICKS, POST_RESET_TICKS) without overflow.

Reset
REQ-019 Asserting RST_I SHALL asynchronously force:
  state=RST_HOLD;
  tftReset=0, byteValid=0, done=0, winErr=0, ready=0, busy=1;
  initAddr=0, pixAddr=0, all counters 0.
REQ-020 Asserting RST_I mid-byte or mid-frame SHALL abort the transfer with no further bytes, and the full power-up sequence SHALL rerun after deassertion.

Verification
REQ-021 Power-up with RESET_TICKS=4, POST_RESET_TICKS=3, ROM {cmd 0x01, delay 2, data 0x55, end}, UNIT_TICKS=5, byteReady=1 -> tftReset low 4 clocks; bytes 0x01(dc0) then 0x55(dc1) at least 10 clocks apart; ready rises.
REQ-022 COLS=4, ROWS=3, window (1,1)-(2,2), PIXEL_BYTES=2 -> 11 window bytes, then pixAddr sequence 5,6,9,10, 8 data bytes MSB first, done pulse once.
REQ-023 Window (3,0)-(2,0) or X1=COLS -> winErr pulse, zero bytes offered, ready stays 1.
REQ-024 byteReady held low 7 clocks on the 3rd pixel byte -> byteData/byteDc stable throughout, no byte lost or duplicated.
REQ-025 continuous=1 with 2x2 panel -> back-to-back frames, each 11+4*PIXEL_BYTES bytes, done pulse per frame, ready never asserted.
REQ-026 RST_I asserted during PIX_SEND -> byteValid=0 and tftReset=0 in the same cycle (asynchronous), init sequence replays after release.
